pp_accum_sequencer: RTL and testbench
=====================================

PP_ACCUM_SEQUENCER -- requirements
Module: pp_accum_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: partial-product width; result width is 2*DATA_WIDTH.
REQ-002 Parameter MAX_TERMS, default 16: maximum partial products per job; CW = clog2(MAX_TERMS+1).
REQ-003 Parameter DRAIN_CYCLES, default 2: cycles waited after the last term is accepted before the adder result is sampled.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 job_start  in  1  job request, sampled only while job_ready=1.
REQ-007 job_terms  in  CW  number of terms in the job (0..MAX_TERMS).
REQ-008 job_ready  out  1  high only in IDLE.
REQ-009 in_pp / in_pp_valid / in_pp_ready  in/in/out  DATA_WIDTH/1/1  term stream; transfer occurs when valid&&ready.
REQ-010 ppa_clear  out  1  one-cycle, active-high clear pulse to the partial-product adder.
REQ-011 ppa_pp / ppa_pp_valid  out  DATA_WIDTH/1  registered term and valid to the adder.
REQ-012 ppa_result / ppa_overflow  in  2*DATA_WIDTH/1  adder accumulator and overflow flag.
REQ-013 res_data / res_overflow / res_valid  out  2*DATA_WIDTH/1/1  captured job result.
REQ-014 res_ready  in  1  result consumer handshake.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, CLEAR, FEED, DRAIN, HOLD; all outputs SHALL be registered.
REQ-017 IDLE: on job_start, latch job_terms into remaining-count and go to CLEAR; job_start in any other state SHALL be ignored.
REQ-018 CLEAR: ppa_clear=1 for exactly one cycle; clear sticky overflow; next state FEED, or DRAIN if remaining-count is 0.
REQ-019 FEED: in_pp_ready=1; each transfer registers in_pp onto ppa_pp with ppa_pp_valid=1 in the following cycle only, and decrements the count; the transfer of the last term moves to DRAIN.
REQ-020 FEED with in_pp_valid=0 SHALL leave ppa_pp_valid=0 and hold the count (stall, no timeout).
REQ-021 DRAIN: wait DRAIN_CYCLES cycles, then capture ppa_result into res_data and the sticky overflow into res_overflow; go to HOLD.
REQ-022 Sticky overflow SHALL be the OR of ppa_overflow over all cycles in FEED and DRAIN.
REQ-023 HOLD: res_valid=1, res_data/res_overflow stable until res_valid&&res_ready, then IDLE in the next cycle.
REQ-024 Latency with back-to-back terms: job_start accepted in cycle 0 -> res_valid first high in cycle N+2+DRAIN_CYCLES (N=2, D=2 -> cycle 6).
REQ-025 job_terms > MAX_TERMS SHALL be saturated to MAX_TERMS.
REQ-026 res_data SHALL hold its last value outside HOLD; it is reset to 0.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, count 0, and job_ready=1, with busy, in_pp_ready, ppa_clear, ppa_pp_valid, res_valid and res_overflow all 0 and ppa_pp/res_data 0.
REQ-028 Reset asserted mid-job SHALL abandon the job with no res_valid pulse; the next job SHALL issue a fresh ppa_clear.

Structure
REQ-029 Package ppa_pkg SHALL hold the FSM state enum, default DATA_WIDTH/MAX_TERMS/DRAIN_CYCLES constants and the count-width function.
REQ-030 Single module, no sub-module; the adder is instantiated alongside it by the integrating top, not inside.

Verification
REQ-031 Terms 0x1234, 0x5678 back-to-back with the real adder attached -> res_data 0x000068AC, res_overflow 0, res_valid in cycle 6.
REQ-032 Terms 0x0800, 0xFC00, then a second job with 0xFC00 -> first result 0x00000400; second result 0xFFFFFC00, which proves that ppa_clear isolated the jobs.
REQ-033 Three terms 0x0001 with 2-cycle gaps in in_pp_valid -> ppa_pp_valid shows exactly 3 pulses, res_data 0x00000003.
REQ-034 res_ready held low for 5 cycles in HOLD -> res_valid and res_data stable for 5 cycles; a job_start pulsed meanwhile is ignored.
REQ-035 reset driven low after the first of 4 terms -> all outputs return to their reset values immediately; a following 1-term job with 0x0005 -> res_data 0x00000005.
REQ-036 job_terms=0 -> ppa_clear pulse, no ppa_pp_valid pulses, res_data 0x00000000 after DRAIN_CYCLES; a stubbed one-cycle ppa_overflow pulse during DRAIN -> res_overflow 1.

Source files
------------

// File: rtl/pp_accum_sequencer_pkg.sv
// rtl/pp_accum_sequencer_pkg.sv - shared constants, state encoding and width helper for the pp accumulation sequencer
package ppa_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_MAX_TERMS    = 16;
    localparam int DEF_DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    function automatic int cnt_width(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/pp_accum_sequencer_if.sv
// rtl/pp_accum_sequencer_if.sv - job, term-stream, adder and result signals of the pp accumulation sequencer
interface pp_accum_sequencer_if
    import ppa_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_TERMS  = DEF_MAX_TERMS
) ();

    localparam int CW = cnt_width(MAX_TERMS);

    logic                    job_start;
    logic [CW-1:0]           job_terms;
    logic                    job_ready;
    logic [DATA_WIDTH-1:0]   in_pp;
    logic                    in_pp_valid;
    logic                    in_pp_ready;
    logic                    ppa_clear;
    logic [DATA_WIDTH-1:0]   ppa_pp;
    logic                    ppa_pp_valid;
    logic [2*DATA_WIDTH-1:0] ppa_result;
    logic                    ppa_overflow;
    logic [2*DATA_WIDTH-1:0] res_data;
    logic                    res_overflow;
    logic                    res_valid;
    logic                    res_ready;
    logic                    busy;

    // The sequencer is the slave of the job/term/result traffic.
    modport slave (
        input  job_start, job_terms, in_pp, in_pp_valid, ppa_result, ppa_overflow, res_ready,
        output job_ready, in_pp_ready, ppa_clear, ppa_pp, ppa_pp_valid,
               res_data, res_overflow, res_valid, busy
    );

    modport master (
        output job_start, job_terms, in_pp, in_pp_valid, ppa_result, ppa_overflow, res_ready,
        input  job_ready, in_pp_ready, ppa_clear, ppa_pp, ppa_pp_valid,
               res_data, res_overflow, res_valid, busy
    );

endinterface

// File: rtl/pp_accum_sequencer.sv
// rtl/pp_accum_sequencer.sv - feeds a job's partial products into an external adder and captures the sum
module pp_accum_sequencer
    import ppa_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MAX_TERMS    = DEF_MAX_TERMS,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    pp_accum_sequencer_if.slave  bus
);

    localparam int CW  = cnt_width(MAX_TERMS);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_CLEAR = ST_CLEAR;
    localparam logic [2:0] S_FEED  = ST_FEED;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_HOLD  = ST_HOLD;

    logic [2:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DCW-1:0]          drain_q, drain_d;
    logic                    ovf_q, ovf_d;
    logic                    job_ready_q, job_ready_d;
    logic                    busy_q, busy_d;
    logic                    in_pp_ready_q, in_pp_ready_d;
    logic                    ppa_clear_q, ppa_clear_d;
    logic [DATA_WIDTH-1:0]   ppa_pp_q, ppa_pp_d;
    logic                    ppa_pp_valid_q, ppa_pp_valid_d;
    logic [2*DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                    res_overflow_q, res_overflow_d;
    logic                    res_valid_q, res_valid_d;
    logic                    xfer;
    logic                    drain_last;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        drain_d        = drain_q;
        ovf_d          = ovf_q;
        ppa_pp_d       = ppa_pp_q;
        ppa_pp_valid_d = 1'b0;
        res_data_d     = res_data_q;
        res_overflow_d = res_overflow_q;
        xfer           = bus.in_pp_valid && in_pp_ready_q;
        drain_last     = (DRAIN_CYCLES <= 1) || (drain_q == DCW'(DRAIN_CYCLES - 1));

        case (state_q)
            S_IDLE: begin
                if (bus.job_start) begin
                    cnt_d   = (bus.job_terms > CW'(MAX_TERMS)) ? CW'(MAX_TERMS) : bus.job_terms;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ovf_d   = 1'b0;
                drain_d = '0;
                state_d = (cnt_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                ovf_d = ovf_q | bus.ppa_overflow;
                if (xfer) begin
                    ppa_pp_d       = bus.in_pp;
                    ppa_pp_valid_d = 1'b1;
                    cnt_d          = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The final drain cycle's overflow is folded in before capture.
                ovf_d = ovf_q | bus.ppa_overflow;
                if (drain_last) begin
                    res_data_d     = bus.ppa_result;
                    res_overflow_d = ovf_d;
                    state_d        = S_HOLD;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            S_HOLD: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they are registered yet aligned.
        job_ready_d   = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        in_pp_ready_d = (state_d == S_FEED);
        ppa_clear_d   = (state_d == S_CLEAR);
        res_valid_d   = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            drain_q        <= '0;
            ovf_q          <= 1'b0;
            job_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            in_pp_ready_q  <= 1'b0;
            ppa_clear_q    <= 1'b0;
            ppa_pp_q       <= '0;
            ppa_pp_valid_q <= 1'b0;
            res_data_q     <= '0;
            res_overflow_q <= 1'b0;
            res_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            drain_q        <= drain_d;
            ovf_q          <= ovf_d;
            job_ready_q    <= job_ready_d;
            busy_q         <= busy_d;
            in_pp_ready_q  <= in_pp_ready_d;
            ppa_clear_q    <= ppa_clear_d;
            ppa_pp_q       <= ppa_pp_d;
            ppa_pp_valid_q <= ppa_pp_valid_d;
            res_data_q     <= res_data_d;
            res_overflow_q <= res_overflow_d;
            res_valid_q    <= res_valid_d;
        end
    end

    assign bus.job_ready    = job_ready_q;
    assign bus.busy         = busy_q;
    assign bus.in_pp_ready  = in_pp_ready_q;
    assign bus.ppa_clear    = ppa_clear_q;
    assign bus.ppa_pp       = ppa_pp_q;
    assign bus.ppa_pp_valid = ppa_pp_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_overflow = res_overflow_q;
    assign bus.res_valid    = res_valid_q;

endmodule

// File: tb/tb_pp_accum_sequencer.sv
// tb/tb_pp_accum_sequencer.sv - self-checking bench for pp_accum_sequencer with a behavioural adder
module tb_pp_accum_sequencer;

    localparam int DW = 16;
    localparam int MT = 16;
    localparam int DC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pp_accum_sequencer_if #(.DATA_WIDTH(DW), .MAX_TERMS(MT)) bus ();

    pp_accum_sequencer #(.DATA_WIDTH(DW), .MAX_TERMS(MT), .DRAIN_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signed adder model: clear on ppa_clear, accumulate sign-extended terms.
    logic [31:0] acc = '0;
    logic        acc_ovf = 1'b0;
    logic        inj_ovf = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (bus.ppa_clear) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (bus.ppa_pp_valid) begin
            acc     <= acc + {{16{bus.ppa_pp[15]}}, bus.ppa_pp};
            if ((acc[31] == bus.ppa_pp[15]) &&
                ((acc + {{16{bus.ppa_pp[15]}}, bus.ppa_pp}) >> 31 != {31'd0, acc[31]}))
                acc_ovf <= 1'b1;
        end
    end
    assign bus.ppa_result   = acc;
    assign bus.ppa_overflow = acc_ovf | inj_ovf;

    int cyc = 0, xfer_cnt = 0, ppv_cnt = 0, clr_cnt = 0, rise_cnt = 0;
    logic prev_rv = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_pp_valid && bus.in_pp_ready) xfer_cnt <= xfer_cnt + 1;
        if (bus.ppa_pp_valid) ppv_cnt <= ppv_cnt + 1;
        if (bus.ppa_clear) clr_cnt <= clr_cnt + 1;
        if (bus.res_valid && !prev_rv) rise_cnt <= rise_cnt + 1;
        prev_rv <= bus.res_valid;
    end

    logic [15:0] terms [32];
    logic feed_on = 1'b0;
    int feed_base = 0, feed_n = 0, gap_mode = 0, idle_left = 0, last_x = 0;
    always @(negedge clk) begin
        int idx;
        if (feed_on) begin
            idx = xfer_cnt - feed_base;
            if (xfer_cnt != last_x) begin
                idle_left = (gap_mode == 2) ? 2 : 0;
                last_x    = xfer_cnt;
            end
            if (idx >= feed_n) begin
                bus.in_pp_valid = 1'b0;
            end else if (idle_left > 0) begin
                bus.in_pp_valid = 1'b0;
                idle_left--;
            end else if (gap_mode == 1 && $urandom_range(0, 2) == 0) begin
                bus.in_pp_valid = 1'b0;
            end else begin
                bus.in_pp_valid = 1'b1;
                bus.in_pp       = terms[idx];
            end
        end else begin
            bus.in_pp_valid = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_job(input int n, output logic [31:0] sum, output logic ovf);
        longint s = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + longint'($signed(terms[i]));
            if (s > longint'(32'sh7FFF_FFFF) || s < -longint'(32'sh7FFF_FFFF) - 1) ovf = 1'b1;
        end
        sum = s[31:0];
    endfunction

    task automatic start_job(input int n_req, input int n_give, input int gap, input string tag);
        int t = 0;
        while (!bus.job_ready && t < 200) begin tick(); t++; end
        chk({tag, "_ready"}, {63'd0, bus.job_ready}, 64'd1);
        feed_base     = xfer_cnt;
        last_x        = xfer_cnt;
        feed_n        = n_give;
        gap_mode      = gap;
        idle_left     = 0;
        feed_on       = 1'b1;
        bus.job_start = 1'b1;
        bus.job_terms = 5'(n_req);
        tick();
        bus.job_start = 1'b0;
    endtask

    task automatic run_job(input int n_req, input int n_give, input int gap, input int hold,
                           input bit inject, input string tag);
        int n_eff, base_ppv, base_clr, c0, t;
        logic [31:0] exp_sum, held;
        logic        exp_ovf;
        n_eff    = (n_req > MT) ? MT : n_req;
        base_ppv = ppv_cnt;
        base_clr = clr_cnt;
        start_job(n_req, n_give, gap, tag);
        c0 = cyc;
        if (inject) begin
            tick();
            inj_ovf = 1'b1;
            tick();
            inj_ovf = 1'b0;
        end
        t = 0;
        while (!bus.res_valid && t < 500) begin tick(); t++; end
        chk({tag, "_resv"}, {63'd0, bus.res_valid}, 64'd1);
        ref_job(n_eff, exp_sum, exp_ovf);
        chk({tag, "_data"}, {32'd0, bus.res_data}, {32'd0, exp_sum});
        chk({tag, "_ovf"}, {63'd0, bus.res_overflow}, {63'd0, exp_ovf | inject});
        chk({tag, "_ppv"}, 64'(ppv_cnt - base_ppv), 64'(n_eff));
        chk({tag, "_clr"}, 64'(clr_cnt - base_clr), 64'd1);
        if (gap == 0) chk({tag, "_lat"}, 64'(cyc - c0 + 1), 64'(n_eff + 2 + DC));
        held = bus.res_data;
        feed_on = 1'b0;
        for (int k = 0; k < hold; k++) begin
            bus.res_ready = 1'b0;
            bus.job_start = (k == 0);
            tick();
            bus.job_start = 1'b0;
            chk({tag, "_hold_v"}, {63'd0, bus.res_valid}, 64'd1);
            chk({tag, "_hold_d"}, {32'd0, bus.res_data}, {32'd0, held});
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_done_v"}, {63'd0, bus.res_valid}, 64'd0);
        chk({tag, "_idle"}, {63'd0, bus.job_ready}, 64'd1);
        tick();
        chk({tag, "_noclr"}, 64'(clr_cnt - base_clr), 64'd1);
        chk({tag, "_keep"}, {32'd0, bus.res_data}, {32'd0, held});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_jr"},   {63'd0, bus.job_ready},    64'd1);
        chk({tag, "_busy"}, {63'd0, bus.busy},         64'd0);
        chk({tag, "_ir"},   {63'd0, bus.in_pp_ready},  64'd0);
        chk({tag, "_clr"},  {63'd0, bus.ppa_clear},    64'd0);
        chk({tag, "_ppv"},  {63'd0, bus.ppa_pp_valid}, 64'd0);
        chk({tag, "_pp"},   {48'd0, bus.ppa_pp},       64'd0);
        chk({tag, "_rv"},   {63'd0, bus.res_valid},    64'd0);
        chk({tag, "_ro"},   {63'd0, bus.res_overflow}, 64'd0);
        chk({tag, "_rd"},   {32'd0, bus.res_data},     64'd0);
    endtask

    initial begin
        int base_rise, t;
        bus.job_start = 1'b0;
        bus.job_terms = '0;
        bus.res_ready = 1'b0;
        bus.in_pp     = '0;
        repeat (3) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        terms[0] = 16'h1234; terms[1] = 16'h5678;
        run_job(2, 2, 0, 0, 1'b0, "b2b");

        terms[0] = 16'h0800; terms[1] = 16'hFC00;
        run_job(2, 2, 0, 1, 1'b0, "iso_a");
        terms[0] = 16'hFC00;
        run_job(1, 1, 0, 0, 1'b0, "iso_b");

        for (int i = 0; i < 3; i++) terms[i] = 16'h0001;
        run_job(3, 3, 2, 0, 1'b0, "gap");

        terms[0] = 16'h7FFF; terms[1] = 16'h0003;
        run_job(2, 2, 0, 5, 1'b0, "hold");

        for (int i = 0; i < 4; i++) terms[i] = 16'(i + 9);
        base_rise = rise_cnt;
        start_job(4, 4, 2, "midrst");
        t = 0;
        while (xfer_cnt - feed_base < 1 && t < 100) begin tick(); t++; end
        chk("midrst_xfer", 64'(xfer_cnt - feed_base), 64'd1);
        rst_n   = 1'b0;
        feed_on = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        terms[0] = 16'h0005;
        run_job(1, 1, 0, 0, 1'b0, "after_rst");
        chk("midrst_norv", 64'(rise_cnt - base_rise), 64'd1);

        run_job(0, 0, 0, 0, 1'b1, "zero_inj");
        run_job(0, 0, 0, 0, 1'b0, "zero");

        for (int i = 0; i < 20; i++) terms[i] = 16'($urandom_range(0, 65535));
        run_job(20, 20, 0, 0, 1'b0, "sat");

        for (int j = 0; j < 8; j++) begin
            int n;
            n = $urandom_range(0, MT);
            for (int i = 0; i < n; i++) terms[i] = 16'($urandom_range(0, 65535));
            run_job(n, n, $urandom_range(0, 1), $urandom_range(0, 3), 1'b0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
